calc_result_display: RTL and testbench

- Downstream stage of the calculator's arithmetic units (multiplier, adder).
- Accepts one 5-bit sign-magnitude result per valid/ready handshake and holds it.
- Drives a 3-digit, time-multiplexed, active-low seven-segment display: sign, tens, ones.
- Handles binary-to-decimal split, leading-zero blanking and negative-zero suppression.

---
 rtl/calc_disp_pkg.sv | 67 ++++++
 rtl/calc_seg_decoder.sv | 26 ++
 rtl/calc_result_display.sv | 127 ++++++++++++
 tb/tb_calc_result_display.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_disp_pkg.sv
// Shared definitions for the calculator result display: active-low segment
// encodings, scan digit indices, result layout and the binary-to-decimal split.
package calc_disp_pkg;

    localparam int SIGN_BIT = 4;
    localparam int MAG_W    = 4;
    localparam int DATA_W   = MAG_W + 1;

    // Segment order {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef logic [1:0] dig_idx_t;

    localparam dig_idx_t DIG_ONES = 2'd0;
    localparam dig_idx_t DIG_TENS = 2'd1;
    localparam dig_idx_t DIG_SIGN = 2'd2;

    // Any digit code of 10 or more decodes to an unlit digit.
    localparam logic [3:0] DIGIT_BLANK = 4'hF;

    typedef struct packed {
        logic       neg;
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_t;

    // Magnitude is at most 15, so a single compare-and-subtract is a full split.
    // A negative zero reports neg = 0 so it is shown as a plain "0".
    function automatic bcd_t split_result(input logic [DATA_W-1:0] value);
        bcd_t             r;
        logic [MAG_W-1:0] mag;
        mag   = value[MAG_W-1:0];
        r.neg = value[SIGN_BIT] && (mag != '0);
        if (mag >= 4'd10) begin
            r.tens = 4'd1;
            r.ones = mag - 4'd10;
        end else begin
            r.tens = 4'd0;
            r.ones = mag;
        end
        return r;
    endfunction

    function automatic logic [2:0] digit_enable(input dig_idx_t idx);
        logic [2:0] en;
        case (idx)
            DIG_ONES: en = 3'b110;
            DIG_TENS: en = 3'b101;
            DIG_SIGN: en = 3'b011;
            default:  en = 3'b111;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/calc_seg_decoder.sv
// Combinational decimal digit to active-low seven-segment pattern; codes of 10
// and above produce an unlit digit.
module calc_seg_decoder
    import calc_disp_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    always_comb begin
        case (i_digit)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/calc_result_display.sv
// Holds one sign-magnitude calculator result per valid/ready handshake and scans it
// onto a 3-digit multiplexed display. Optional error digit: `define CALC_DISP_ERR_EN.
module calc_result_display
    import calc_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int HOLD_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
`ifdef CALC_DISP_ERR_EN
    input  logic              res_err,
`endif
    output logic              res_ready,
    output logic [2:0]        an,
    output logic [6:0]        seg
);

    localparam int DIV_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

    logic [DATA_W-1:0] r_value;
    logic              r_err;
    logic [HOLD_W-1:0] r_hold;
    logic [DIV_W-1:0]  r_div;
    dig_idx_t          r_idx;
    logic [2:0]        r_an;
    logic [6:0]        r_seg;

    logic              w_capture;
    logic              w_err_in;
    logic              w_scan_tick;
    bcd_t              w_bcd;
    logic [3:0]        w_dec_digit;
    logic [6:0]        w_dec_seg;
    logic [6:0]        w_next_seg;
    logic [2:0]        w_next_an;

`ifdef CALC_DISP_ERR_EN
    assign w_err_in = res_err;
`else
    assign w_err_in = 1'b0;
`endif

    assign res_ready   = (r_hold == '0);
    assign w_capture   = res_valid && res_ready;
    assign w_scan_tick = (r_div == DIV_LAST);

    // NOTE: all state uses non-blocking assignments so every register samples the
    // pre-edge values; reset is synchronous, so it is tested inside the clocked branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_value <= '0;
            r_err   <= 1'b0;
            r_hold  <= '0;
        end else begin
            if (w_capture) begin
                r_value <= res_data;
                r_err   <= w_err_in;
                r_hold  <= HOLD_LOAD;
            end else if (r_hold != '0) begin
                r_hold <= r_hold - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= '0;
            r_idx <= DIG_ONES;
        end else if (w_scan_tick) begin
            r_div <= '0;
            r_idx <= (r_idx == DIG_SIGN) ? DIG_ONES : r_idx + 2'd1;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign w_bcd = split_result(r_value);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_dec_digit = DIGIT_BLANK;
        case (r_idx)
            DIG_ONES: w_dec_digit = w_bcd.ones;
            DIG_TENS: if (w_bcd.tens != 4'd0) w_dec_digit = w_bcd.tens;
            default:  ;
        endcase
    end

    calc_seg_decoder u_dec (
        .i_digit (w_dec_digit),
        .o_seg   (w_dec_seg)
    );

    // The sign position never goes through the decoder; an error overrides everything.
    always_comb begin
        w_next_an  = digit_enable(r_idx);
        w_next_seg = w_dec_seg;
        if (r_err) begin
            w_next_seg = (r_idx == DIG_ONES) ? SEG_E : SEG_BLANK;
        end else if (r_idx == DIG_SIGN) begin
            w_next_seg = w_bcd.neg ? SEG_MINUS : SEG_BLANK;
        end
    end

    // Index and value are both state, so the registered pair can never mix a
    // new digit position with a stale value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an  <= 3'b111;
            r_seg <= SEG_BLANK;
        end else begin
            r_an  <= w_next_an;
            r_seg <= w_next_seg;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;

endmodule

// File: tb/tb_calc_result_display.sv
// Directed bench for calc_result_display: a slow-scan instance with hold-off and a
// fast-scan always-ready instance, checked against a queue of modelled displays.
module tb_calc_result_display;

    localparam logic [6:0] SEG_TBL [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    typedef struct packed {
        logic [6:0] ones;
        logic [6:0] tens;
        logic [6:0] sign;
    } disp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_valid, f_valid;
    logic [4:0] a_data, f_data;
    logic       a_ready, f_ready;
    logic [2:0] a_an, f_an;
    logic [6:0] a_seg, f_seg;
`ifdef CALC_DISP_ERR_EN
    logic       a_err, f_err;
`endif

    disp_t sb_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    always #5 clk = ~clk;

    calc_result_display #(.REFRESH_DIV(4), .HOLD_CYCLES(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .res_valid (a_valid),
        .res_data  (a_data),
`ifdef CALC_DISP_ERR_EN
        .res_err   (a_err),
`endif
        .res_ready (a_ready),
        .an        (a_an),
        .seg       (a_seg)
    );

    calc_result_display #(.REFRESH_DIV(1), .HOLD_CYCLES(0)) dut_fast (
        .clk       (clk),
        .rst       (rst),
        .res_valid (f_valid),
        .res_data  (f_data),
`ifdef CALC_DISP_ERR_EN
        .res_err   (f_err),
`endif
        .res_ready (f_ready),
        .an        (f_an),
        .seg       (f_seg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic disp_t model(input logic [4:0] d, input logic e);
        disp_t      x;
        int         mag;
        mag = int'(d[3:0]);
        if (e) begin
            x.ones = 7'h06;
            x.tens = 7'h7F;
            x.sign = 7'h7F;
        end else begin
            x.ones = SEG_TBL[mag % 10];
            x.tens = (mag >= 10) ? SEG_TBL[mag / 10] : 7'h7F;
            x.sign = (d[4] && mag != 0) ? 7'h3F : 7'h7F;
        end
        return x;
    endfunction

    function automatic logic [6:0] seg_for(input disp_t x, input logic [2:0] an_v);
        case (an_v)
            3'b110:  return x.ones;
            3'b101:  return x.tens;
            3'b011:  return x.sign;
            default: return 7'hxx;
        endcase
    endfunction

    // Called on a falling edge; returns on a falling edge with a_ready high or a FAIL.
    task automatic wait_ready();
        int guard = 0;
        while (a_ready !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("ready_wait", {31'd0, a_ready}, 32'd1);
    endtask

    // Returns on the falling edge right after the capturing rising edge.
    task automatic capture_a(input logic [4:0] d, input logic e);
        wait_ready();
        a_data  = d;
        a_valid = 1'b1;
`ifdef CALC_DISP_ERR_EN
        a_err   = e;
`endif
        sb_q.push_back(model(d, e));
        @(negedge clk);
        a_valid = 1'b0;
    endtask

    task automatic check_display(input bit fast, input int cycles, input string tag);
        disp_t      got;
        disp_t      exp;
        logic [2:0] an_s;
        logic [6:0] seg_s;
        got = 'x;
        repeat (2) @(negedge clk);
        for (int k = 0; k < cycles; k++) begin
            an_s  = fast ? f_an : a_an;
            seg_s = fast ? f_seg : a_seg;
            case (an_s)
                3'b110:  got.ones = seg_s;
                3'b101:  got.tens = seg_s;
                3'b011:  got.sign = seg_s;
                default: ;
            endcase
            @(negedge clk);
        end
        check({tag, "_sb_nonempty"}, {31'd0, sb_q.size() != 0}, 32'd1);
        exp = (sb_q.size() != 0) ? sb_q.pop_front() : '1;
        check({tag, "_ones"}, got.ones, exp.ones);
        check({tag, "_tens"}, got.tens, exp.tens);
        check({tag, "_sign"}, got.sign, exp.sign);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         cnt;
        logic [2:0] e_an;
        logic [2:0] prev_an;

        rst     = 1'b1;
        a_valid = 1'b0;
        a_data  = '0;
        f_valid = 1'b0;
        f_data  = '0;
`ifdef CALC_DISP_ERR_EN
        a_err   = 1'b0;
        f_err   = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_an", a_an, 3'b111);
        check("rst_seg", a_seg, 7'h7F);
        check("rst_ready", a_ready, 1'b1);
        check("rst_fast_an", f_an, 3'b111);
        check("rst_fast_ready", f_ready, 1'b1);
        rst = 1'b0;

        // 1: idle scan of +0, four cycles per digit
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            e_an = ~(3'b001 << (k / 4));
            check($sformatf("t1_an_%0d", k), a_an, e_an);
            check($sformatf("t1_seg_%0d", k), a_seg, (k < 4) ? 7'h40 : 7'h7F);
        end

        // 2: -6 with an 8-cycle hold-off
        capture_a(5'b10110, 1'b0);
        cnt = 0;
        while (a_ready === 1'b0 && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        check("t2_hold_len", cnt, 8);
        check_display(1'b0, 12, "t2");

        // 3: negative zero, then +15
        capture_a(5'b10000, 1'b0);
        check_display(1'b0, 12, "t3_neg0");
        capture_a(5'b01111, 1'b0);
        check_display(1'b0, 12, "t3_p15");

        // 4: +12, then 3 offered throughout the hold window
        capture_a(5'b01100, 1'b0);
        a_data  = 5'b00011;
        a_valid = 1'b1;
        sb_q.push_back(model(5'b00011, 1'b0));
        @(negedge clk);
        cnt = 1;
        while (a_ready === 1'b0 && cnt < 20) begin
            check($sformatf("t4_keep_%0d", cnt), a_seg, seg_for(sb_q[0], a_an));
            cnt++;
            @(negedge clk);
        end
        check("t4_hold_len", cnt, 8);
        @(negedge clk);
        a_valid = 1'b0;
        check("t4_captured", a_ready, 1'b0);
        void'(sb_q.pop_front());
        check_display(1'b0, 12, "t4");

        // 5: back-to-back captures into the always-ready, every-cycle-scan instance
        prev_an = f_an;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t5_ready_%0d", i), f_ready, 1'b1);
            if (i == 2) begin
                check("t5_live_v1", f_seg, seg_for(sb_q[0], f_an));
                void'(sb_q.pop_front());
            end
            f_data  = 5'(i + 1);
            f_valid = 1'b1;
            sb_q.push_back(model(5'(i + 1), 1'b0));
            @(negedge clk);
            check($sformatf("t5_rot_%0d", i), f_an, {prev_an[1:0], prev_an[2]});
            prev_an = f_an;
        end
        check("t5_ready_3", f_ready, 1'b1);
        check("t5_live_v2", f_seg, seg_for(sb_q[0], f_an));
        void'(sb_q.pop_front());
        f_valid = 1'b0;
        @(negedge clk);
        check("t5_rot_3", f_an, {prev_an[1:0], prev_an[2]});
        check("t5_live_v3", f_seg, seg_for(sb_q[0], f_an));
        check_display(1'b1, 3, "t5");

        // 6: reset in the middle of the hold window after -9
        capture_a(5'b11001, 1'b0);
        @(negedge clk);
        check("t6_mid_hold", a_ready, 1'b0);
        rst = 1'b1;
        sb_q.delete();
        sb_q.push_back(model(5'b00000, 1'b0));
        @(negedge clk);
        check("t6_rst_an", a_an, 3'b111);
        check("t6_rst_seg", a_seg, 7'h7F);
        check("t6_rst_ready", a_ready, 1'b1);
        rst = 1'b0;
        check_display(1'b0, 12, "t6");

`ifdef CALC_DISP_ERR_EN
        capture_a(5'b10111, 1'b1);
        check_display(1'b0, 12, "t7_err");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
